// File: rtl/bsram_arbiter.sv
// Two-port arbiter in front of a single-port BSRAM: the CPU read port and a loader
// read/write port share the macro, with a burst limit so the loader cannot starve the CPU.
module bsram_arbiter #(
   parameter int AW        = 11,
   parameter int DW        = 16,
   parameter int RD_LAT    = 1,
   parameter int MAX_BURST = 4
) (
   input  logic          clk,
   input  logic          rst,
   // CPU fetch port
   input  logic          cpu_req,
   input  logic [AW-1:0] cpu_adr,
   output logic          cpu_gnt,
   output logic [DW-1:0] cpu_rdata,
   output logic          cpu_rvalid,
   // loader port
   input  logic          ld_req,
   input  logic          ld_we,
   input  logic [AW-1:0] ld_adr,
   input  logic [DW-1:0] ld_wdata,
   output logic          ld_gnt,
   output logic [DW-1:0] ld_rdata,
   output logic          ld_rvalid,
   input  logic          ld_lock,
   // BSRAM side
   output logic          mem_ce,
   output logic          mem_wre,
   output logic [AW-1:0] mem_ad,
   output logic [DW-1:0] mem_din,
   input  logic [DW-1:0] mem_dout,
   output logic          cpu_stall,
   // debug view of the last cycle's grant owner: 0 idle, 1 cpu, 2 loader
   output logic [1:0]    arb_state
);

   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_CPU = 2'd1, ST_LD = 2'd2} state_t;
   typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_CPU = 2'd1, OWN_LD = 2'd2} owner_t;

   localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);

   state_t              state_reg, state_next;
   logic [3:0]          burst_cnt_reg, burst_cnt_next;
   logic [AW-1:0]       mem_ad_reg;
   logic [DW-1:0]       mem_din_reg;
   logic [2*RD_LAT-1:0] own_reg, own_next;
   logic [1:0]          own_tail;
   owner_t              own_in;

   logic                cpu_win, ld_win, ld_wr_acc, ld_rd_acc;

   // response ports: index 0 is the CPU, index 1 the loader
   logic [1:0]          rsp_valid;
   logic [1:0][DW-1:0]  rsp_rdata, rsp_rdata_reg;

   // Grant decision; nothing is granted while reset is held.
   always_comb begin
      cpu_win = 1'b0;
      ld_win  = 1'b0;
      if (rst) begin
         if (ld_lock) begin
            ld_win = ld_req;
         end else if (ld_req && !(cpu_req && burst_cnt_reg == BURST_MAX)) begin
            ld_win = 1'b1;
         end else begin
            cpu_win = cpu_req;
         end
      end
   end

   assign ld_wr_acc = ld_win & ld_we;
   assign ld_rd_acc = ld_win & ~ld_we;

   assign cpu_gnt   = cpu_win;
   assign ld_gnt    = ld_win;
   assign cpu_stall = rst & cpu_req & ~cpu_win;

   assign mem_ce    = cpu_win | ld_win;
   assign mem_wre   = ld_wr_acc;
   assign mem_ad    = cpu_win ? cpu_adr : (ld_win ? ld_adr : mem_ad_reg);
   assign mem_din   = ld_wr_acc ? ld_wdata : mem_din_reg;

   always_comb begin
      burst_cnt_next = burst_cnt_reg;
      if (cpu_win || !cpu_req) begin
         burst_cnt_next = '0;
      end else if (ld_win && burst_cnt_reg != BURST_MAX) begin
         burst_cnt_next = burst_cnt_reg + 4'd1;
      end
   end

   always_comb begin
      state_next = ST_IDLE;
      if (cpu_win) begin
         state_next = ST_CPU;
      end else if (ld_win) begin
         state_next = ST_LD;
      end
   end

   always_comb begin
      own_in = OWN_NONE;
      if (cpu_win) begin
         own_in = OWN_CPU;
      end else if (ld_rd_acc) begin
         own_in = OWN_LD;
      end
   end

   // The owner of each accepted read travels alongside the BSRAM read latency.
   generate
      if (RD_LAT == 1) begin : g_own_single
         assign own_next = own_in;
      end else begin : g_own_shift
         assign own_next = {own_reg[2*RD_LAT-3:0], own_in};
      end
   endgenerate

   assign own_tail = own_reg[2*RD_LAT-1 -: 2];

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
         // owner codes are port index + 1
         assign rsp_valid[gi] = (own_tail == 2'(gi + 1));
         assign rsp_rdata[gi] = rsp_valid[gi] ? mem_dout : rsp_rdata_reg[gi];
      end
   endgenerate

   assign cpu_rvalid = rsp_valid[0];
   assign ld_rvalid  = rsp_valid[1];
   assign cpu_rdata  = rsp_rdata[0];
   assign ld_rdata   = rsp_rdata[1];
   assign arb_state  = state_reg;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg     <= ST_IDLE;
         burst_cnt_reg <= '0;
         mem_ad_reg    <= '0;
         mem_din_reg   <= '0;
         own_reg       <= '0;
         rsp_rdata_reg <= '0;
      end else begin
         state_reg     <= state_next;
         burst_cnt_reg <= burst_cnt_next;
         mem_ad_reg    <= mem_ad;
         mem_din_reg   <= mem_din;
         own_reg       <= own_next;
         rsp_rdata_reg <= rsp_rdata;
      end
   end

endmodule

// File: tb/tb_bsram_arbiter.sv
// Bench for bsram_arbiter: three instances (read latency 1, 2, 3) share one stimulus
// stream, each with its own BSRAM model, checked against a cycle-level reference.
module tb_bsram_arbiter;

   localparam int AW   = 11;
   localparam int DW   = 16;
   localparam int NI   = 3;
   localparam int MAXB = 4;
   localparam int NCYC = 1024;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          cpu_req = 1'b0;
   logic [AW-1:0] cpu_adr = '0;
   logic          ld_req = 1'b0;
   logic          ld_we = 1'b0;
   logic [AW-1:0] ld_adr = '0;
   logic [DW-1:0] ld_wdata = '0;
   logic          ld_lock = 1'b0;

   logic          cpu_gnt_w [NI];
   logic [DW-1:0] cpu_rdata_w [NI];
   logic          cpu_rvalid_w [NI];
   logic          ld_gnt_w [NI];
   logic [DW-1:0] ld_rdata_w [NI];
   logic          ld_rvalid_w [NI];
   logic          mem_ce_w [NI];
   logic          mem_wre_w [NI];
   logic [AW-1:0] mem_ad_w [NI];
   logic [DW-1:0] mem_din_w [NI];
   logic [DW-1:0] mem_dout_w [NI];
   logic          cpu_stall_w [NI];
   logic [1:0]    arb_state_w [NI];

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] preload(input int a);
      return DW'((a * 37) ^ 16'hC3C3);
   endfunction

   for (genvar gi = 0; gi < NI; gi++) begin : g_inst
      logic [DW-1:0] mem [0:(1<<AW)-1];
      logic [DW-1:0] dpipe [0:gi];

      initial begin
         for (int k = 0; k < (1 << AW); k++) mem[k] = preload(k);
         for (int k = 0; k <= gi; k++) dpipe[k] <= '0;
      end

      // write-first BSRAM with gi+1 cycles of read latency
      always @(posedge clk) begin
         if (mem_ce_w[gi]) begin
            if (mem_wre_w[gi]) begin
               mem[mem_ad_w[gi]] = mem_din_w[gi];
               dpipe[0] <= mem_din_w[gi];
            end else begin
               dpipe[0] <= mem[mem_ad_w[gi]];
            end
         end
         for (int k = 1; k <= gi; k++) dpipe[k] <= dpipe[k-1];
      end

      assign mem_dout_w[gi] = dpipe[gi];

      bsram_arbiter #(.AW(AW), .DW(DW), .RD_LAT(gi + 1), .MAX_BURST(MAXB)) u_dut (
         .clk        (clk),
         .rst        (rst),
         .cpu_req    (cpu_req),
         .cpu_adr    (cpu_adr),
         .cpu_gnt    (cpu_gnt_w[gi]),
         .cpu_rdata  (cpu_rdata_w[gi]),
         .cpu_rvalid (cpu_rvalid_w[gi]),
         .ld_req     (ld_req),
         .ld_we      (ld_we),
         .ld_adr     (ld_adr),
         .ld_wdata   (ld_wdata),
         .ld_gnt     (ld_gnt_w[gi]),
         .ld_rdata   (ld_rdata_w[gi]),
         .ld_rvalid  (ld_rvalid_w[gi]),
         .ld_lock    (ld_lock),
         .mem_ce     (mem_ce_w[gi]),
         .mem_wre    (mem_wre_w[gi]),
         .mem_ad     (mem_ad_w[gi]),
         .mem_din    (mem_din_w[gi]),
         .mem_dout   (mem_dout_w[gi]),
         .cpu_stall  (cpu_stall_w[gi]),
         .arb_state  (arb_state_w[gi])
      );
   end

   // reference model state
   logic [DW-1:0] ref_mem [0:(1<<AW)-1];
   int            ref_burst;
   logic [AW-1:0] ref_ad;
   logic [DW-1:0] ref_din;
   int            acc_kind [NCYC];   // 0 none, 1 cpu read, 2 loader read
   logic [DW-1:0] acc_data [NCYC];
   logic [DW-1:0] hold_cpu [NI];
   logic [DW-1:0] hold_ld [NI];
   bit            prev_cpu_gnt, prev_ld_gnt;
   int            cyc;
   int            passed, failed, total;
   int            obs_cpu_gnt, obs_ld_gnt;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      total++;
      assert (obs === exp_v) passed++;
      else begin
         failed++;
         $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp_v);
      end
   endtask

   task automatic clear_model();
      ref_burst    = 0;
      ref_ad       = '0;
      ref_din      = '0;
      prev_cpu_gnt = 1'b0;
      prev_ld_gnt  = 1'b0;
      for (int k = 0; k < NCYC; k++) acc_kind[k] = 0;
      for (int i = 0; i < NI; i++) begin
         hold_cpu[i] = '0;
         hold_ld[i]  = '0;
      end
   endtask

   task automatic set_rst(input logic v);
      rst = v;
      if (!v) clear_model();
   endtask

   task automatic exp_grant(output bit eg_cpu, output bit eg_ld);
      eg_cpu = 1'b0;
      eg_ld  = 1'b0;
      if (rst) begin
         if (ld_lock) eg_ld = ld_req;
         else if (cpu_req && (!ld_req || ref_burst >= MAXB)) eg_cpu = 1'b1;
         else eg_ld = ld_req;
      end
   endtask

   task automatic check_cycle();
      bit ec, el;
      exp_grant(ec, el);
      if (cpu_gnt_w[0]) obs_cpu_gnt++;
      if (ld_gnt_w[0]) obs_ld_gnt++;
      for (int i = 0; i < NI; i++) begin
         int            lat, idx, kind;
         logic [DW-1:0] d;
         logic [1:0]    st;
         logic [AW-1:0] ead;
         lat  = i + 1;
         idx  = cyc - lat;
         kind = 0;
         d    = '0;
         if (idx >= 0 && idx < NCYC && rst) begin
            kind = acc_kind[idx];
            d    = acc_data[idx];
         end
         st  = !rst ? 2'd0 : (prev_cpu_gnt ? 2'd1 : (prev_ld_gnt ? 2'd2 : 2'd0));
         ead = ec ? cpu_adr : (el ? ld_adr : ref_ad);
         chk($sformatf("L%0d cpu_gnt", lat), 32'(cpu_gnt_w[i]), 32'(ec));
         chk($sformatf("L%0d ld_gnt", lat), 32'(ld_gnt_w[i]), 32'(el));
         chk($sformatf("L%0d cpu_stall", lat), 32'(cpu_stall_w[i]), 32'(rst && cpu_req && !ec));
         chk($sformatf("L%0d mem_ce", lat), 32'(mem_ce_w[i]), 32'(ec || el));
         chk($sformatf("L%0d mem_wre", lat), 32'(mem_wre_w[i]), 32'(el && ld_we));
         chk($sformatf("L%0d mem_ad", lat), 32'(mem_ad_w[i]), 32'(ead));
         chk($sformatf("L%0d mem_din", lat), 32'(mem_din_w[i]), 32'((el && ld_we) ? ld_wdata : ref_din));
         chk($sformatf("L%0d cpu_rvalid", lat), 32'(cpu_rvalid_w[i]), 32'(kind == 1));
         chk($sformatf("L%0d ld_rvalid", lat), 32'(ld_rvalid_w[i]), 32'(kind == 2));
         chk($sformatf("L%0d cpu_rdata", lat), 32'(cpu_rdata_w[i]), 32'((kind == 1) ? d : hold_cpu[i]));
         chk($sformatf("L%0d ld_rdata", lat), 32'(ld_rdata_w[i]), 32'((kind == 2) ? d : hold_ld[i]));
         chk($sformatf("L%0d arb_state", lat), 32'(arb_state_w[i]), 32'(st));
      end
   endtask

   task automatic update_model();
      bit ec, el;
      exp_grant(ec, el);
      if (!rst) begin
         clear_model();
      end else begin
         for (int i = 0; i < NI; i++) begin
            int idx;
            idx = cyc - (i + 1);
            if (idx >= 0 && idx < NCYC) begin
               if (acc_kind[idx] == 1) hold_cpu[i] = acc_data[idx];
               if (acc_kind[idx] == 2) hold_ld[i] = acc_data[idx];
            end
         end
         if (cyc < NCYC) begin
            acc_kind[cyc] = ec ? 1 : ((el && !ld_we) ? 2 : 0);
            acc_data[cyc] = ec ? ref_mem[cpu_adr] : ref_mem[ld_adr];
         end
         if (el && ld_we) begin
            ref_mem[ld_adr] = ld_wdata;
            ref_din         = ld_wdata;
         end
         if (ec) ref_ad = cpu_adr;
         else if (el) ref_ad = ld_adr;
         if (ec || !cpu_req) ref_burst = 0;
         else if (el && ref_burst < MAXB) ref_burst++;
         prev_cpu_gnt = ec;
         prev_ld_gnt  = el;
      end
      cyc++;
   endtask

   task automatic run_cycle();
      @(negedge clk);
      check_cycle();
      @(posedge clk);
      update_model();
      #1;
   endtask

   task automatic drain(input int n);
      for (int k = 0; k < n; k++) run_cycle();
   endtask

   task automatic rand_inputs(input bit allow_new);
      if (!cpu_req || prev_cpu_gnt) begin
         cpu_req = allow_new && ($urandom_range(0, 3) != 0);
         cpu_adr = AW'($urandom_range(0, 15)) + AW'(11'h7F8);
      end
      if (!ld_req || prev_ld_gnt) begin
         ld_req   = allow_new && ($urandom_range(0, 2) == 0);
         ld_we    = 1'($urandom_range(0, 1));
         ld_adr   = AW'($urandom_range(0, 15)) + AW'(11'h7F8);
         ld_wdata = DW'($urandom);
      end
      if (!allow_new) ld_lock = 1'b0;
      else if ($urandom_range(0, 24) == 0) ld_lock = ~ld_lock;
   endtask

   initial begin
      passed = 0;
      failed = 0;
      total  = 0;
      cyc    = 0;
      obs_cpu_gnt = 0;
      obs_ld_gnt  = 0;
      for (int k = 0; k < (1 << AW); k++) ref_mem[k] = preload(k);
      clear_model();
      @(posedge clk);
      #1;

      // reset held with both ports requesting: everything must read zero
      cpu_req = 1'b1; cpu_adr = 11'h003;
      ld_req  = 1'b1; ld_we = 1'b0; ld_adr = 11'h004;
      set_rst(1'b0);
      drain(3);
      set_rst(1'b1);
      run_cycle();                       // loader wins the first edge
      ld_req = 1'b0;
      run_cycle();                       // pending CPU read of 0x003 now granted
      cpu_req = 1'b0;
      drain(4);

      // CPU-only back-to-back reads of 0x000..0x002
      cpu_req = 1'b1;
      for (int a = 0; a < 3; a++) begin
         cpu_adr = AW'(a);
         run_cycle();
      end
      cpu_req = 1'b0;
      drain(4);

      // both requesting continuously: LD x4 then CPU, repeating
      cpu_req = 1'b1; cpu_adr = 11'h005;
      ld_req  = 1'b1; ld_we = 1'b0; ld_adr = 11'h100;
      obs_cpu_gnt = 0;
      obs_ld_gnt  = 0;
      for (int k = 0; k < 15; k++) begin
         run_cycle();
         if (prev_ld_gnt) ld_adr = ld_adr + 11'd1;
      end
      chk("burst_cpu_grants", 32'(obs_cpu_gnt), 32'd3);
      chk("burst_ld_grants", 32'(obs_ld_gnt), 32'd12);
      cpu_req = 1'b0;
      ld_req  = 1'b0;
      drain(4);

      // download lock: loader writes 0xA5A5 to 0x7FF, CPU must wait
      ld_lock = 1'b1;
      cpu_req = 1'b1; cpu_adr = 11'h7FF;
      ld_req  = 1'b1; ld_we = 1'b1; ld_adr = 11'h7FF; ld_wdata = 16'hA5A5;
      obs_cpu_gnt = 0;
      drain(10);
      chk("lock_cpu_grants", 32'(obs_cpu_gnt), 32'd0);
      ld_lock = 1'b0;
      ld_req  = 1'b0;
      run_cycle();
      cpu_req = 1'b0;
      drain(4);
      for (int i = 0; i < NI; i++)
         chk($sformatf("L%0d lock_readback", i + 1), 32'(cpu_rdata_w[i]), 32'h0000A5A5);

      // loader write then immediate loader read of the same word
      ld_req = 1'b1; ld_we = 1'b1; ld_adr = 11'h010; ld_wdata = 16'h1234;
      run_cycle();
      ld_we = 1'b0;
      run_cycle();
      ld_req = 1'b0;
      drain(4);
      for (int i = 0; i < NI; i++)
         chk($sformatf("L%0d wr_rd_readback", i + 1), 32'(ld_rdata_w[i]), 32'h00001234);

      // reset one cycle after an accepted CPU read drops that read
      cpu_req = 1'b1; cpu_adr = 11'h020;
      run_cycle();
      cpu_adr = 11'h021;
      set_rst(1'b0);
      run_cycle();
      set_rst(1'b1);
      run_cycle();
      cpu_req = 1'b0;
      drain(5);

      // interleaved CPU and loader reads
      for (int k = 0; k < 8; k++) begin
         cpu_req = (k % 2 == 0);
         cpu_adr = AW'(k * 3);
         ld_req  = (k % 2 == 1);
         ld_we   = 1'b0;
         ld_adr  = AW'(k * 3 + 1);
         run_cycle();
      end
      cpu_req = 1'b0;
      ld_req  = 1'b0;
      drain(4);

      // random traffic around the address wrap point
      for (int k = 0; k < 300; k++) begin
         rand_inputs(1'b1);
         run_cycle();
      end
      for (int k = 0; k < 20; k++) begin
         rand_inputs(1'b0);
         run_cycle();
      end
      cpu_req = 1'b0;
      ld_req  = 1'b0;
      drain(5);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/bsram_arbiter.md
BSRAM_ARBITER -- requirements
Module: bsram_arbiter

Interface
REQ-001 The block SHALL have parameter AW, default 11, meaning BSRAM word-address width.
REQ-002 The block SHALL have parameter DW, default 16, meaning BSRAM data width.
REQ-003 The block SHALL have parameter RD_LAT, default 1, range 1..3, meaning cycles from the address cycle to valid mem_dout.
REQ-004 The block SHALL have parameter MAX_BURST, default 4, range 1..15, meaning the maximum number of consecutive loader grants while the CPU waits.
REQ-005 The block SHALL have port clk, input, 1 bit: the clock; all logic is rising-edge.
REQ-006 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have CPU read-port signals: cpu_req in 1 (fetch request); cpu_adr in AW; cpu_gnt out 1; cpu_rdata out DW; cpu_rvalid out 1.
REQ-008 The block SHALL have loader-port signals: ld_req in 1; ld_we in 1 (1 = write); ld_adr in AW; ld_wdata in DW; ld_gnt out 1; ld_rdata out DW; ld_rvalid out 1.
REQ-009 The block SHALL have port ld_lock, input, 1 bit: while 1, the CPU is never granted (program download).
REQ-010 The block SHALL have BSRAM-side signals: mem_ce out 1; mem_wre out 1; mem_ad out AW; mem_din out DW; mem_dout in DW.
REQ-011 The block SHALL have port cpu_stall, output, 1 bit: equal to cpu_req & ~cpu_gnt.

Function
REQ-012 The block SHALL grant at most one requester per cycle; cpu_gnt and ld_gnt are combinational, and a request is accepted in the cycle its gnt is 1.
REQ-013 The block SHALL, in an accept cycle, drive mem_ce=1 and mem_ad to the winner's address; it SHALL drive mem_wre=1 and mem_din=ld_wdata only for an accepted loader write; otherwise mem_ce=0, mem_wre=0, and mem_ad/mem_din hold their last values.
REQ-014 The block SHALL apply this priority: ld_lock=1 grants the loader only; otherwise the loader wins, unless burst_cnt==MAX_BURST and cpu_req=1, in which case the CPU wins.
REQ-015 The block SHALL keep burst_cnt (4 bit), which increments on each loader grant while cpu_req=1, saturates at MAX_BURST, clears on a CPU grant, and clears in any cycle with cpu_req=0.
REQ-016 The block SHALL keep arbiter state IDLE/CPU/LD, equal to the last cycle's grant owner (IDLE = no grant); the state is observable for debug only and does not alter priority.
REQ-017 The block SHALL track each accepted read with an RD_LAT-deep owner shift register (entries: none/cpu/ld); writes enter as none.
REQ-018 The block SHALL, exactly RD_LAT cycles after an accepted read, pulse the owner's rvalid for 1 cycle and drive the owner's rdata with mem_dout.
REQ-019 The block SHALL keep rdata registered, holding its value between rvalid pulses.
REQ-020 The block SHALL sustain back-to-back reads at a throughput of one per cycle, with responses returned in acceptance order and tagged per owner.
REQ-021 The block SHALL, for a loader write followed next cycle by a read of the same address, return the newly written data (the BSRAM is write-first; no bypass logic is required).
REQ-022 The block SHALL treat a request that is not granted as still pending: the requester holds req/adr/data stable, and the block has no timeout.
REQ-023 The block SHALL apply ld_lock changes in the same cycle; in-flight CPU reads still return their rvalid.
REQ-024 The block SHALL wrap addresses modulo 2^AW with no range checking.

Reset
REQ-025 The block SHALL, while rst=0, force cpu_gnt, ld_gnt, cpu_rvalid, ld_rvalid, mem_ce, mem_wre and cpu_stall to 0, clear mem_ad, mem_din, cpu_rdata, ld_rdata and burst_cnt to 0, set state to IDLE, and set the owner pipeline to none.
REQ-026 The block SHALL drop reads that are in flight when reset is asserted: no rvalid is produced after rst is released.
REQ-027 The block SHALL accept a grant in the first rising edge after rst deasserts.

Verification
REQ-028 Verification SHALL cover: CPU-only reads of 0x000,0x001,0x002 back-to-back with RD_LAT=1 -> cpu_rvalid on cycles 1,2,3 with the preloaded words, and cpu_stall=0.
REQ-029 Verification SHALL cover: cpu_req and ld_req both held 1 continuously with MAX_BURST=4 -> grant pattern LD,LD,LD,LD,CPU repeating, and cpu_stall=1 on loader cycles.
REQ-030 Verification SHALL cover: ld_lock=1 with a 10-cycle loader write of 0xA5A5 to 0x7FF while cpu_req=1 -> zero CPU grants; then a CPU read of 0x7FF -> rdata 0xA5A5.
REQ-031 Verification SHALL cover: a loader write of 0x1234 to 0x010 followed next cycle by a loader read of 0x010 -> ld_rvalid with 0x1234, and cpu_rvalid stays 0.
REQ-032 Verification SHALL cover: rst pulsed low one cycle after a CPU read is accepted (RD_LAT=2) -> no cpu_rvalid, all outputs 0 during reset, and a grant on the first edge after release.
REQ-033 Verification SHALL cover: interleaved CPU/loader reads with RD_LAT=3 -> each rvalid lands on the correct port in order, with correct data.
